mips_multicycle_ctrl: RTL and testbench

- Multi-cycle MIPS control FSM; drives the 3-bit ALU operation select and consumes the ALU zero flag.
- Accepts one instruction (opcode/funct) per handshake and sequences DECODE/EXEC/ADDR/MEM/BR/WB.
- Emits datapath strobes: register write, memory request, PC update.
- Sits between the fetch stage and the ALU/register-file/memory datapath.

---
 rtl/mips_multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: takes one opcode/funct per handshake, sequences
// DECODE/EXEC/ADDR/MEM/BR/WB and drives ALU select plus datapath strobes.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       instr_valid_i,
    output logic       instr_ready_o,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ack_i,
    output logic [2:0] alu_control_o,
    output logic       alu_src_b_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       illegal_o,
    output logic       mem_err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_ADDR, S_MEM, S_BR, S_WB
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q, funct_d;
    logic [7:0] cnt_q, cnt_d;

    logic       is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_j;
    logic [2:0] alu_op;
    logic       timeout;

    assign timeout = (cnt_q == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            funct_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
            cnt_q    <= cnt_d;
        end
    end

    // Instruction class and ALU operation from the latched fields.
    always_comb begin
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_j   = 1'b0;
        alu_op = 3'd0;
        case (opcode_q)
            6'h00: begin
                is_r = 1'b1;
                case (funct_q)
                    6'h20: alu_op = 3'd0;
                    6'h22: alu_op = 3'd1;
                    6'h24: alu_op = 3'd2;
                    6'h25: alu_op = 3'd3;
                    6'h27: alu_op = 3'd4;
                    6'h2A: alu_op = 3'd5;
                    default: is_r = 1'b0;
                endcase
            end
            6'h08: begin is_i = 1'b1; alu_op = 3'd0; end
            6'h0C: begin is_i = 1'b1; alu_op = 3'd2; end
            6'h0D: begin is_i = 1'b1; alu_op = 3'd3; end
            6'h0A: begin is_i = 1'b1; alu_op = 3'd5; end
            6'h23: is_lw  = 1'b1;
            6'h2B: is_sw  = 1'b1;
            6'h04: is_beq = 1'b1;
            6'h05: is_bne = 1'b1;
            6'h02: is_j   = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        funct_d       = funct_q;
        cnt_d         = cnt_q;
        instr_ready_o = 1'b0;
        alu_control_o = 3'd0;
        alu_src_b_o   = 1'b0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_write_o   = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        pc_write_o    = 1'b0;
        pc_src_o      = 2'd0;
        illegal_o     = 1'b0;
        mem_err_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    opcode_d = opcode_i;
                    funct_d  = funct_i;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_r || is_i)          state_d = S_EXEC;
                else if (is_lw || is_sw)   state_d = S_ADDR;
                else if (is_beq || is_bne) state_d = S_BR;
                else if (is_j) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 2'd2;
                    state_d    = S_IDLE;
                end else begin
                    illegal_o  = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_EXEC: begin
                alu_control_o = alu_op;
                alu_src_b_o   = is_i;
                state_d       = S_WB;
            end
            S_ADDR: begin
                alu_src_b_o = 1'b1;
                cnt_d       = '0;
                state_d     = S_MEM;
            end
            S_MEM: begin
                mem_read_o  = is_lw;
                mem_write_o = is_sw;
                // An ack on the final allowed cycle still completes the access.
                if (mem_ack_i) begin
                    if (is_lw) state_d = S_WB;
                    else begin
                        pc_write_o = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (timeout) begin
                    mem_err_o  = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_BR: begin
                alu_control_o = 3'd1;
                pc_write_o    = 1'b1;
                pc_src_o      = (is_beq ? zero_i : ~zero_i) ? 2'd1 : 2'd0;
                state_d       = S_IDLE;
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                pc_write_o   = 1'b1;
                reg_dst_o    = is_r;
                mem_to_reg_o = is_lw;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: each step drives one cycle of inputs and queues the expected
// output vector for that cycle; a negedge checker pops and compares.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, instr_valid, instr_ready, zero, mem_ack;
    logic [5:0] opcode, funct;
    logic [2:0] alu_control;
    logic       alu_src_b, reg_dst, mem_to_reg, reg_write, mem_read, mem_write;
    logic       pc_write, illegal, mem_err;
    logic [1:0] pc_src;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [14:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .opcode_i(opcode), .funct_i(funct), .zero_i(zero), .mem_ack_i(mem_ack),
        .alu_control_o(alu_control), .alu_src_b_o(alu_src_b), .reg_dst_o(reg_dst),
        .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
        .illegal_o(illegal), .mem_err_o(mem_err)
    );

    always #5 clk = ~clk;

    // Bit order: ready, alu[2:0], srcb, regdst, memtoreg, rw, mr, mw, pw, pcsrc[1:0], illegal, merr
    function automatic logic [14:0] ov(input logic rdy, input logic [2:0] alu,
        input logic sb_, input logic rd, input logic m2r, input logic rw,
        input logic mr, input logic mw, input logic pw, input logic [1:0] ps,
        input logic il, input logic me);
        return {rdy, alu, sb_, rd, m2r, rw, mr, mw, pw, ps, il, me};
    endfunction

    logic [14:0] obs;
    assign obs = {instr_ready, alu_control, alu_src_b, reg_dst, mem_to_reg, reg_write,
                  mem_read, mem_write, pc_write, pc_src, illegal, mem_err};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
            end
        end
    end

    task automatic step(input logic rst, input logic v, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic ack,
                        input logic [14:0] e, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = rst; instr_valid = v; opcode = op; funct = fn; zero = z; mem_ack = ack;
        x.v = e; x.tag = tag;
        sb.push_back(x);
    endtask

    logic [14:0] IDLE_V, ZERO_V;

    // ALU instruction: accept, DECODE (valid held high to show it is ignored), EXEC, WB.
    task automatic run_alu(input logic [5:0] op, input logic [5:0] fn,
                           input logic [2:0] alu, input logic isr, input string tag);
        step(1, 1, op, fn, 0, 0, IDLE_V, {tag, "_accept"});
        step(1, 1, 6'h3F, 6'h00, 0, 0, ZERO_V, {tag, "_decode"});
        step(1, 0, 0, 0, 0, 0, ov(0, alu, ~isr, 0, 0, 0, 0, 0, 0, 0, 0, 0), {tag, "_exec"});
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, isr, 0, 1, 0, 0, 1, 0, 0, 0), {tag, "_wb"});
    endtask

    task automatic run_br(input logic [5:0] op, input logic z, input logic [1:0] ps,
                          input string tag);
        step(1, 1, op, 0, 0, 0, IDLE_V, {tag, "_accept"});
        step(1, 0, 0, 0, 0, 0, ZERO_V, {tag, "_decode"});
        step(1, 0, 0, 0, z, 0, ov(0, 1, 0, 0, 0, 0, 0, 0, 1, ps, 0, 0), {tag, "_br"});
    endtask

    initial begin
        IDLE_V = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ZERO_V = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0; instr_valid = 1'b1; opcode = 6'h00; funct = 6'h20;
        zero = 1'b0; mem_ack = 1'b0;

        // Reset held 3 edges with instr_valid high: nothing may be accepted.
        step(0, 1, 6'h00, 6'h20, 0, 0, IDLE_V, "rst_0");
        step(0, 1, 6'h00, 6'h20, 0, 0, IDLE_V, "rst_1");
        step(1, 0, 0, 0, 0, 0, IDLE_V, "rst_2");
        step(1, 0, 0, 0, 0, 0, IDLE_V, "rst_release");

        run_alu(6'h00, 6'h20, 3'd0, 1, "add");
        run_alu(6'h00, 6'h22, 3'd1, 1, "sub");
        run_alu(6'h00, 6'h24, 3'd2, 1, "and");
        run_alu(6'h00, 6'h25, 3'd3, 1, "or");
        run_alu(6'h00, 6'h27, 3'd4, 1, "nor");
        run_alu(6'h00, 6'h2A, 3'd5, 1, "slt");
        run_alu(6'h08, 6'h3F, 3'd0, 0, "addi");
        run_alu(6'h0C, 6'h00, 3'd2, 0, "andi");
        run_alu(6'h0D, 6'h00, 3'd3, 0, "ori");
        run_alu(6'h0A, 6'h00, 3'd5, 0, "slti");

        run_br(6'h04, 1, 2'd1, "beq_z1");
        run_br(6'h04, 0, 2'd0, "beq_z0");
        run_br(6'h05, 1, 2'd0, "bne_z1");
        run_br(6'h05, 0, 2'd1, "bne_z0");

        // j
        step(1, 1, 6'h02, 0, 0, 0, IDLE_V, "j_accept");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0), "j_decode");

        // lw with ack after 2 wait cycles
        step(1, 1, 6'h23, 0, 0, 0, IDLE_V, "lw_accept");
        step(1, 0, 0, 0, 0, 0, ZERO_V, "lw_decode");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_addr");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "lw_mem0");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "lw_mem1");
        step(1, 0, 0, 0, 0, 1, ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "lw_mem_ack");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0), "lw_wb");

        // sw with immediate ack
        step(1, 1, 6'h2B, 0, 0, 0, IDLE_V, "sw_accept");
        step(1, 0, 0, 0, 0, 0, ZERO_V, "sw_decode");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw_addr");
        step(1, 0, 0, 0, 0, 1, ov(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "sw_mem_ack");

        // sw with no ack: 4 MEM cycles, last one aborts
        step(1, 1, 6'h2B, 0, 0, 0, IDLE_V, "swto_accept");
        step(1, 0, 0, 0, 0, 0, ZERO_V, "swto_decode");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "swto_addr");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "swto_wait");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), "swto_timeout");

        // ack on the timeout cycle: completes without mem_err
        step(1, 1, 6'h2B, 0, 0, 0, IDLE_V, "swack_accept");
        step(1, 0, 0, 0, 0, 0, ZERO_V, "swack_decode");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "swack_addr");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "swack_wait");
        step(1, 0, 0, 0, 0, 1, ov(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "swack_last");

        // illegal opcode and illegal R-type funct
        step(1, 1, 6'h3F, 0, 0, 0, IDLE_V, "ill_accept");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), "ill_decode");
        step(1, 1, 6'h00, 6'h21, 0, 0, IDLE_V, "illf_accept");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), "illf_decode");

        // reset during lw MEM wait aborts with no strobes
        step(1, 1, 6'h23, 0, 0, 0, IDLE_V, "lwrst_accept");
        step(1, 0, 0, 0, 0, 0, ZERO_V, "lwrst_decode");
        step(1, 0, 0, 0, 0, 0, ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lwrst_addr");
        step(0, 0, 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "lwrst_mem");
        step(1, 0, 0, 0, 0, 1, IDLE_V, "lwrst_after");
        step(1, 0, 0, 0, 0, 0, IDLE_V, "lwrst_idle");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
